// File: rtl/prim_rr_arb_pkg.sv
// prim_rr_arb_pkg: shared types for the registered round-robin arbiter
package prim_rr_arb_pkg;

    typedef enum logic [1:0] {
        IdleSt  = 2'b00,
        GrantSt = 2'b01
    } arb_state_e;

endpackage

// File: rtl/prim_rr_arb_pick.sv
// prim_rr_arb_pick: combinational round-robin pick of the first request at or above ptr, wrapping modulo N
module prim_rr_arb_pick #(
    parameter int N    = 8,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic [N-1:0]    o_onehot,
    output logic [IdxW-1:0] o_idx,
    output logic            o_any
);
    localparam int L = $clog2(N);
    localparam int P = 1 << L;

    logic [N-1:0]       w_mask;
    logic [1:0][N-1:0]  w_in;
    logic               w_masked_any;
    logic [L-1:0]       w_sel;

    for (genvar i = 0; i < N; i++) begin : g_mask
        assign w_mask[i] = i_ptr <= IdxW'(i);
    end

    assign w_in[0] = i_req & w_mask;
    assign w_in[1] = i_req;

    for (genvar p = 0; p < 2; p++) begin : g_pass
        for (genvar l = 0; l <= L; l++) begin : g_lvl
            localparam int W = P >> l;
            logic [W-1:0]        w_v;
            logic [W-1:0][L-1:0] w_x;
            for (genvar i = 0; i < W; i++) begin : g_node
                if (l == 0) begin : g_leaf
                    if (i < N) begin : g_real
                        assign w_v[i] = w_in[p][i];
                    end else begin : g_pad
                        assign w_v[i] = 1'b0;
                    end
                    assign w_x[i] = L'(i);
                end else begin : g_inner
                    assign w_v[i] = g_lvl[l-1].w_v[2*i] | g_lvl[l-1].w_v[2*i+1];
                    assign w_x[i] = g_lvl[l-1].w_v[2*i] ? g_lvl[l-1].w_x[2*i] : g_lvl[l-1].w_x[2*i+1];
                end
            end
        end
    end

    assign w_masked_any = g_pass[0].g_lvl[L].w_v[0];
    assign o_any        = g_pass[1].g_lvl[L].w_v[0];
    assign w_sel        = w_masked_any ? g_pass[0].g_lvl[L].w_x[0] : g_pass[1].g_lvl[L].w_x[0];
    assign o_idx        = o_any ? IdxW'(w_sel) : '0;
    assign o_onehot     = o_any ? ({{(N-1){1'b0}}, 1'b1} << o_idx) : '0;

endmodule

// File: rtl/prim_rr_arb_onehot.sv
// prim_rr_arb_onehot: registered round-robin arbiter with onehot/index grant and valid/ready handshake
module prim_rr_arb_onehot
    import prim_rr_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IdxW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [N-1:0]    gnt_oh_o,
    output logic [IdxW-1:0] idx_o,
    output logic [N-1:0]    ack_o
);
    arb_state_e      r_state, w_state_n;
    logic            r_valid, w_valid_n;
    logic [N-1:0]    r_gnt, w_gnt_n;
    logic [IdxW-1:0] r_idx, w_idx_n;
    logic [IdxW-1:0] r_ptr, w_ptr_n;
    logic            w_hs;
    logic [IdxW:0]   w_inc;
    logic [IdxW-1:0] w_ptr_inc;
    logic [IdxW-1:0] w_pick_ptr;
    logic [N-1:0]    w_pick_req;
    logic [N-1:0]    w_pick_oh;
    logic [IdxW-1:0] w_pick_idx;
    logic            w_pick_any;

    assign w_hs       = r_valid & ready_i;
    assign w_inc      = {1'b0, r_idx} + (IdxW+1)'(1);
    assign w_ptr_inc  = (w_inc == (IdxW+1)'(N)) ? '0 : w_inc[IdxW-1:0];
    assign w_pick_req = (r_state == GrantSt) ? (req_i & ~r_gnt) : req_i;
    assign w_pick_ptr = w_hs ? w_ptr_inc : r_ptr;

    prim_rr_arb_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .i_req    (w_pick_req),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // next grant: pick from IDLE, hold until handshake, then chain to the next requester or drain
    always_comb begin
        w_state_n = r_state;
        w_valid_n = r_valid;
        w_gnt_n   = r_gnt;
        w_idx_n   = r_idx;
        w_ptr_n   = r_ptr;
        case (r_state)
            IdleSt: begin
                if (w_pick_any) begin
                    w_state_n = GrantSt;
                    w_valid_n = 1'b1;
                    w_gnt_n   = w_pick_oh;
                    w_idx_n   = w_pick_idx;
                end
            end
            GrantSt: begin
                if (w_hs) begin
                    w_ptr_n   = w_ptr_inc;
                    w_state_n = w_pick_any ? GrantSt : IdleSt;
                    w_valid_n = w_pick_any;
                    w_gnt_n   = w_pick_oh;
                    w_idx_n   = w_pick_idx;
                end
            end
            default: begin
                w_state_n = IdleSt;
                w_valid_n = 1'b0;
                w_gnt_n   = '0;
                w_idx_n   = '0;
            end
        endcase
    end

    // state, grant and priority pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IdleSt;
            r_valid <= 1'b0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_valid <= w_valid_n;
            r_gnt   <= w_gnt_n;
            r_idx   <= w_idx_n;
            r_ptr   <= w_ptr_n;
        end
    end

    assign valid_o  = r_valid;
    assign gnt_oh_o = r_gnt;
    assign idx_o    = r_idx;
    assign ack_o    = r_gnt & {N{w_hs}};

    a_valid_any: assert property (@(posedge clk_i) disable iff (rst_i) valid_o == (|gnt_oh_o));
    a_onehot0:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_oh_o));
    a_idx_match: assert property (@(posedge clk_i) disable iff (rst_i) gnt_oh_o[idx_o] == valid_o);
    a_stable:    assert property (@(posedge clk_i) disable iff (rst_i)
                                  valid_o && !ready_i |=> $stable(gnt_oh_o) && $stable(idx_o));

endmodule

// File: doc/prim_rr_arb_onehot.md
Name: prim_rr_arb_onehot

Overview:
- Registered round-robin arbiter for N requesters with a valid/ready grant handshake.
- Produces a onehot grant vector, its binary index and a valid flag.
- Sits directly upstream of the onehot checker; that checker's parameters are AddrWidth=IdxW, OneHotWidth=N, AddrCheck=1, EnableCheck=1, StrictCheck=1.
- The checker's oh_i, addr_i and en_i inputs connect to gnt_oh_o, idx_o and valid_o.

Parameters:
- N, default 8: number of requesters, 2..32; need not be a power of two.
- IdxW, default $clog2(N): width of the index output; N <= 2**IdxW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- req_i  in  N  request per requester; level-sensitive.
- ready_i  in  1  consumer accepts the current grant.
- valid_o  out  1  a grant is presented.
- gnt_oh_o  out  N  onehot0 grant, registered.
- idx_o  out  IdxW  binary index of the granted requester, registered.
- ack_o  out  N  gnt_oh_o & {N{valid_o & ready_i}}; combinational; pulses for one cycle on handshake.

Behaviour:
- Reset: while rst_i is high at a clock edge, the following are set.
  - state = IDLE, valid_o = 0, gnt_oh_o = 0, idx_o = 0, ptr = 0.
  - Reset mid-grant drops the grant with no ack_o.
  - ack_o = 0 while valid_o = 0.
- ptr is the priority pointer, IdxW bits.
  - The pick scans req from ptr upward: ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - The first set bit wins.
  - Wrap is modulo N, not modulo 2**IdxW.
- FSM states: IDLE, GRANT.
- IDLE:
  - If |req_i: register the pick into gnt_oh_o/idx_o, set valid_o = 1, go to GRANT.
  - Latency is 1 cycle: req_i seen at edge k gives valid_o high after edge k.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt_oh_o, idx_o and valid_o hold stable until handshake (valid_o & ready_i).
  - This holds even if req_i[idx_o] drops. Requesters must hold req until ack; a bench assertion checks this, and the RTL does not rely on it.
- Handshake cycle:
  - ack_o[idx_o] = 1.
  - ptr <= (idx_o == N-1) ? 0 : idx_o + 1.
  - Let rem = req_i & ~gnt_oh_o.
  - If rem != 0: pick from rem using the updated pointer (idx_o+1 mod N), register the new grant and stay in GRANT. Back-to-back grants have no bubble.
  - If rem == 0: clear gnt_oh_o and idx_o to 0, set valid_o = 0, go to IDLE.
- A lone requester holding req continuously gets a new grant every other cycle: its own bit is masked in the handshake cycle, so IDLE re-grants it after a 1-cycle bubble.
- Invariants, every cycle:
  - valid_o == |gnt_oh_o.
  - $onehot0(gnt_oh_o).
  - gnt_oh_o[idx_o] == valid_o.
  - These guarantee err_o = 0 at the downstream checker.
  - Add ASSERTs for each, plus gnt_oh_o/idx_o stability while valid_o & !ready_i.
- Fairness: any requester holding req is granted within N handshakes.
- Arithmetic: the pointer increment is done at IdxW+1 bits, compared against N-1, and truncated.

Decomposition:
- Package prim_rr_arb_pkg:
  - arb_state_e enum {IdleSt, GrantSt}, 2-bit encoding with a default-to-IdleSt branch.
- Sub-module prim_rr_arb_pick, combinational:
  - Inputs: req, ptr. Outputs: onehot, idx, any.
  - Implementation: masked/unmasked two-pass priority using explicit binary trees for depth.
  - Reused for both the IDLE pick and the handshake-cycle pick.

Test Plan:
1. Reset: hold rst_i=1 with req_i=8'hFF -> valid_o=0, gnt_oh_o=0, idx_o=0, ack_o=0. Release; one cycle later gnt_oh_o=8'h01, idx_o=0.
2. Rotation: req_i=8'hFF held, ready_i=1 -> idx_o sequence 0,1,2,...,7,0 with no bubbles; ack_o one-hot each cycle.
3. Backpressure: req_i=8'h24, ready_i=0 for 5 cycles -> gnt_oh_o=8'h04, idx_o=2 stable throughout. Then ready_i=1 -> ack_o=8'h04; next gnt_oh_o=8'h20, idx_o=5.
4. Wrap with N=5 (IdxW=3): grant idx 4 acked with req_i=5'h11 -> ptr=0, next idx_o=0 (not 5).
5. Drain/bubble: single req_i=8'h08 held, ready_i=1 -> valid_o pattern 1,0,1,0; idx_o=3 whenever valid.
6. Reset mid-grant: valid_o=1, idx_o=6, rst_i pulsed -> next cycle valid_o=0, ack_o never asserted, ptr=0. A checker instance is bound throughout all tests and err_o stays 0.
